// File: rtl/counter_pkg.sv
// Shared definitions for the modulo up/down counter: direction encoding and
// the saturating load helper.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Clamp a load value into 0..modulus-1; modulus is 33 bits so 2^32 fits.
  function automatic logic [31:0] sat_load(input logic [31:0] d,
                                           input logic [32:0] modulus);
    logic [32:0] max_val;
    max_val = modulus - 33'd1;
    if ({1'b0, d} > max_val) begin
      return max_val[31:0];
    end
    return d;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count logic: one step in the requested direction,
// wrapping or stopping at the terminal value.
module counter_next #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             one_shot,
  output logic [WIDTH-1:0] nxt,
  output logic             at_term
);
  import counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] term_val;

  // Explicit wrap targets keep q inside 0..MODULUS-1 even when MODULUS < 2^WIDTH.
  always_comb begin
    term_val = (up == DIR_DOWN) ? '0 : MAX_VAL;
    at_term  = (q == term_val);
    nxt      = q;
    if (at_term) begin
      if (!one_shot) begin
        nxt = (up == DIR_UP) ? '0 : MAX_VAL;
      end
    end else if (up == DIR_UP) begin
      nxt = q + WIDTH'(1);
    end else begin
      nxt = q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with clear, saturating load, pause and one-shot
// stop; holds only the registers and the clear > load > step > hold mux.
module mod_updown_counter #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             T,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             one_shot,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done
);
  import counter_pkg::*;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must be 2..2^WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_val;
  logic             at_term;

  counter_next #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .q       (count_q),
    .up      (up),
    .one_shot(one_shot),
    .nxt     (step_val),
    .at_term (at_term)
  );

  // A finished one-shot run freezes q even if up changes afterwards.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    if (clear) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (load) begin
      count_d = WIDTH'(sat_load(32'(d), 33'(MODULUS)));
      done_d  = 1'b0;
    end else if (T) begin
      if (!(one_shot && done_q)) begin
        count_d = step_val;
        if (one_shot && at_term) begin
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign q    = count_q;
  assign done = done_q;
  assign tc   = T & at_term;

endmodule
